// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, fetches one word at a time over req/gnt/rvalid,
// and holds the result in a one-deep slot with stall and redirect/flush.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst,
   output logic        o_valid
);
   typedef enum logic [1:0] {FETCH, WAIT, FLUSH} state_t;
   state_t state, state_nx;
   logic [31:0] pc;
   logic load, consume, unused_lsb;
   assign unused_lsb = ^redirect_pc_i[1:0];
   assign imem_addr_o = pc;
   assign imem_req_o = (state == FETCH) & ~redirect_i & ~(o_valid & stall_i);
   assign consume = o_valid & ~stall_i;
   assign load = ~redirect_i & (state == WAIT) & imem_rvalid_i;
   // A redirect turns a live request into one whose response must be discarded.
   always_comb begin
      state_nx = redirect_i ? ((state == FETCH || imem_rvalid_i) ? FETCH : FLUSH)
               : (state == FETCH) ? ((imem_req_o & imem_gnt_i) ? WAIT : FETCH)
               : imem_rvalid_i ? FETCH : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         o_pc    <= 32'h0;
         o_inst  <= NOP_INST;
         o_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (redirect_i) begin
            pc      <= {redirect_pc_i[31:2], 2'b00};
            o_inst  <= NOP_INST;
            o_valid <= 1'b0;
         end else if (load) begin
            pc      <= pc + 32'd4;
            o_pc    <= pc;
            o_inst  <= imem_rdata_i;
            o_valid <= 1'b1;
         end else if (consume) begin
            o_inst  <= NOP_INST;
            o_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a scoreboard of expected deliveries
// popped by a monitor whenever the slot is consumed.
module tb_inst_fetch;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic [31:0] imem_addr_o, imem_rdata_i = 32'h0;
   logic [31:0] o_pc, o_inst;
   logic        o_valid;
   logic        req2, rvalid2 = 1'b0, o_valid2;
   logic [31:0] addr2, rdata2 = 32'h0, o_pc2, o_inst2;
   int errors = 0, checks = 0;
   int lat = 1, cnt = 0;
   logic pend = 1'b0, hs, hs2;
   logic [31:0] paddr = 32'h0, a2;
   typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
   exp_t exp_q[$];

   inst_fetch dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .o_pc(o_pc), .o_inst(o_inst), .o_valid(o_valid)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0),
      .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_gnt_i(1'b1), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
      .o_pc(o_pc2), .o_inst(o_inst2), .o_valid(o_valid2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc = pc;
      e.inst = inst;
      exp_q.push_back(e);
   endtask

   task automatic settle;
      #1;
   endtask

   // One clock cycle; inputs for the next cycle become valid at posedge+2.
   task automatic tick;
      @(negedge clk);
      hs = imem_req_o & imem_gnt_i;
      hs2 = req2;
      a2 = addr2;
      if (hs) begin
         pend = 1'b1;
         paddr = imem_addr_o;
         cnt = lat;
      end
      @(posedge clk);
      #2;
      imem_rvalid_i = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = paddr ^ K;
            pend = 1'b0;
         end
      end
      rvalid2 = hs2;
      rdata2 = a2 ^ K;
   endtask

   always @(negedge clk) begin
      if (!rst && o_valid && !stall_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h inst %h expected none", o_pc, o_inst);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("deliver_pc", o_pc, e.pc);
            chk("deliver_inst", o_inst, e.inst);
         end
      end
   end

   initial begin
      push(32'h0, 32'hA5A5_0000);
      push(32'h4, 32'hA5A5_0004);
      push(32'h8, 32'hA5A5_0008);
      push(32'hC, 32'hA5A5_000C);
      push(32'h10, 32'hA5A5_0010);
      push(32'h14, 32'hA5A5_0014);
      push(32'h18, 32'hA5A5_0018);
      push(32'h1C, 32'hA5A5_001C);
      push(32'h100, 32'hA5A5_0100);
      push(32'h300, 32'hA5A5_0300);
      push(32'h0, 32'hA5A5_0000);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      rst = 1'b0;
      imem_gnt_i = 1'b1;
      settle;
      chk("c0_req", {31'h0, imem_req_o}, 32'h1);
      chk("c0_addr", imem_addr_o, 32'h0);
      chk("c0_addr2", addr2, 32'hFFFF_FFFC);
      tick;
      settle;
      chk("c1_valid", {31'h0, o_valid}, 32'h0);
      chk("c1_req", {31'h0, imem_req_o}, 32'h0);
      tick;
      settle;
      chk("c2_valid", {31'h0, o_valid}, 32'h1);
      chk("c2_addr", imem_addr_o, 32'h4);
      chk("wrap_valid", {31'h0, o_valid2}, 32'h1);
      chk("wrap_pc", o_pc2, 32'hFFFF_FFFC);
      chk("wrap_inst", o_inst2, 32'h5A5A_FFFC);
      chk("wrap_addr", addr2, 32'h0);
      repeat (4) tick;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle;
         chk("stall_req", {31'h0, imem_req_o}, 32'h0);
         chk("stall_valid", {31'h0, o_valid}, 32'h1);
         chk("stall_pc", o_pc, 32'h8);
         chk("stall_inst", o_inst, 32'hA5A5_0008);
         tick;
      end
      stall_i = 1'b0;
      settle;
      chk("unstall_req", {31'h0, imem_req_o}, 32'h1);
      chk("unstall_addr", imem_addr_o, 32'hC);
      tick;
      tick;
      imem_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle;
         chk("nognt_req", {31'h0, imem_req_o}, 32'h1);
         chk("nognt_addr", imem_addr_o, 32'h10);
         tick;
      end
      imem_gnt_i = 1'b1;
      lat = 3;
      tick;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         settle;
         chk("slow_valid", {31'h0, o_valid}, 32'h0);
         chk("slow_req", {31'h0, imem_req_o}, 32'h0);
         tick;
      end
      settle;
      chk("slow_rise", {31'h0, o_valid}, 32'h1);
      repeat (6) tick;
      lat = 3;
      settle;
      chk("c25_addr", imem_addr_o, 32'h20);
      tick;
      lat = 1;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0102;
      settle;
      chk("redir_req", {31'h0, imem_req_o}, 32'h0);
      tick;
      redirect_i = 1'b0;
      settle;
      chk("flush_req", {31'h0, imem_req_o}, 32'h0);
      chk("flush_valid", {31'h0, o_valid}, 32'h0);
      tick;
      settle;
      chk("flush_drop_req", {31'h0, imem_req_o}, 32'h0);
      tick;
      settle;
      chk("target_req", {31'h0, imem_req_o}, 32'h1);
      chk("target_addr", imem_addr_o, 32'h100);
      chk("target_valid", {31'h0, o_valid}, 32'h0);
      repeat (3) tick;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      tick;
      redirect_i = 1'b0;
      settle;
      chk("rv_redir_valid", {31'h0, o_valid}, 32'h0);
      chk("rv_redir_addr", imem_addr_o, 32'h200);
      chk("rv_redir_req", {31'h0, imem_req_o}, 32'h1);
      repeat (2) tick;
      stall_i = 1'b1;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0300;
      settle;
      chk("sr_valid", {31'h0, o_valid}, 32'h1);
      chk("sr_pc", o_pc, 32'h200);
      chk("sr_req", {31'h0, imem_req_o}, 32'h0);
      tick;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      settle;
      chk("sr_flush_valid", {31'h0, o_valid}, 32'h0);
      chk("sr_flush_inst", o_inst, 32'h0);
      chk("sr_addr", imem_addr_o, 32'h300);
      chk("sr_req_after", {31'h0, imem_req_o}, 32'h1);
      repeat (2) tick;
      lat = 2;
      settle;
      chk("c38_addr", imem_addr_o, 32'h304);
      tick;
      lat = 1;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      imem_gnt_i = 1'b0;
      settle;
      chk("mrst_req", {31'h0, imem_req_o}, 32'h1);
      chk("mrst_addr", imem_addr_o, 32'h0);
      chk("mrst_valid", {31'h0, o_valid}, 32'h0);
      chk("mrst_pc", o_pc, 32'h0);
      tick;
      imem_gnt_i = 1'b1;
      settle;
      chk("stale_valid", {31'h0, o_valid}, 32'h0);
      chk("stale_addr", imem_addr_o, 32'h0);
      repeat (2) tick;
      imem_gnt_i = 1'b0;
      repeat (4) tick;
      chk("queue_left", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit driving the fetch-to-decode pipeline register. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. It presents each fetched instruction with its PC on a one-deep output slot, and it handles decode-stage stall and branch/jump redirect, including discarding in-flight responses. Sits between instruction memory and the fetch/decode register. Its o_pc/o_inst feed that register's pc/inst inputs.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded by reset; first fetch address
- NOP_INST, 32'h0000_0000, value driven on o_inst when no valid instruction is held
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stall_i  input  1  downstream not accepting the current output this cycle
- redirect_i  input  1  branch/jump taken; flush and refetch from redirect_pc_i
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 0
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch word address, always 4-byte aligned
- imem_gnt_i  input  1  memory accepts request this cycle (imem_req_o & imem_gnt_i)
- imem_rvalid_i  input  1  read data valid; at most one response per accepted request, earliest the cycle after grant
- imem_rdata_i  input  32  instruction word
- o_pc  output  32  PC of held instruction
- o_inst  output  32  held instruction
- o_valid  output  1  o_pc/o_inst hold an instruction not yet consumed

## Operation
- Internal registers: pc[31:0], state, output slot (o_pc, o_inst, o_valid). At most one request outstanding.
- States:
  - FETCH: no request outstanding.
  - WAIT: one outstanding request, response to be kept.
  - FLUSH: one outstanding request, response to be discarded.
- imem_addr_o = pc combinationally. imem_req_o = (state==FETCH) & ~redirect_i & ~(o_valid & stall_i).
- Consumption: the slot is consumed in any cycle with o_valid=1 and stall_i=0. o_valid then falls next cycle unless a new instruction is loaded that same cycle.
- FETCH:
  - On imem_req_o & imem_gnt_i, go to WAIT. pc is unchanged until the response arrives.
- WAIT:
  - On imem_rvalid_i: o_inst<=imem_rdata_i, o_pc<=pc, o_valid<=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), go to FETCH.
- FLUSH:
  - On imem_rvalid_i, drop data, go to FETCH. The slot is not touched.
- Redirect has priority over everything except rst. In the cycle redirect_i=1:
  - pc<={redirect_pc_i[31:2],2'b00}; o_valid<=0; o_inst<=NOP_INST.
  - FETCH goes to FETCH. No request is issued this cycle, so a redirect with gnt high has no effect on memory.
  - WAIT goes to FLUSH. If rvalid arrives the same cycle, go to FETCH and drop the data.
  - FLUSH stays in FLUSH, or goes to FETCH if rvalid arrives the same cycle.
- Stall and redirect together: redirect wins. The held instruction is flushed.
- imem_rvalid_i while in FETCH is ignored. This covers stale responses after reset.
- When o_valid=0, o_inst=NOP_INST and o_pc holds its last value.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, o_pc=32'h0, o_inst=NOP_INST, o_valid=0. Consequently imem_req_o=1 and imem_addr_o=RESET_PC in the first cycle after rst deasserts.
- rst mid-operation: all of the above is applied at the next edge. An outstanding request is abandoned, and its late response is ignored because state is FETCH. The memory side must tolerate this.
- Latency:
  - Grant in cycle N, rvalid in cycle N+k (k≥1): o_valid=1 and next imem_req_o=1 in cycle N+k+1.
  - With zero-wait memory (gnt=1, k=1): one instruction every 2 cycles.
- Stall:
  - While o_valid & stall_i, no new request is issued and o_pc/o_inst/o_valid are held bit-stable.
  - An outstanding request that completes during a stall cannot occur, because requests are only issued when the slot is free or being consumed.
- Redirect: the first request to the new target is issued in the cycle after redirect_i if state is FETCH. Otherwise it is issued the cycle after the discarded response.

## Test plan
- Reset, gnt=1, 1-cycle memory returning addr^32'hA5A5_0000:
  - o_valid pulses every 2 cycles.
  - o_pc sequence is 0,4,8,12, with o_inst matching.
- Stall 3 cycles while o_valid=1, o_pc=8:
  - outputs stay stable.
  - imem_req_o=0 throughout.
  - next request to 12 follows the cycle stall_i falls.
- gnt held low 4 cycles, then rvalid delayed 3 cycles:
  - imem_req_o/imem_addr_o stay 0x10 until grant.
  - o_valid rises exactly 1 cycle after rvalid.
- redirect_i to 32'h0000_0102 while in WAIT for 0x20:
  - the 0x20 response is dropped.
  - o_valid=0.
  - next fetch is at 0x100.
  - o_pc=0x100 is delivered.
- Redirect in the same cycle as rvalid, and separately in the same cycle as stall_i with o_valid=1:
  - both flush.
  - neither loads the slot.
  - fetch resumes at the target.
- RESET_PC=32'hFFFF_FFFC: the second fetch address wraps to 0. Separately, assert rst while in WAIT with a response arriving 1 cycle after reset: the response is ignored, and the fetch restarts at RESET_PC.
